// File: rtl/peripheral_putresult.sv
// Result presenter: captures an ALU result plus flags and shows them
// one byte at a time, stepped by a synchronized push-button.
module peripheral_putresult #(
    parameter int NBYTES      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*NBYTES-1:0] result,
    input  logic [3:0]          flags,
    input  logic                resultvalid,
    input  logic                nextpulse,
    output logic [7:0]          outputdata,
    output logic [2:0]          dataoutput_i,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [2:0] LAST = 3'(NBYTES);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;
    logic                   step;

    logic [2:0]          idx_q, idx_d;
    logic [8*NBYTES-1:0] res_q, res_d;
    logic [3:0]          flg_q, flg_d;
    logic [7:0]          data_q, data_d;

    // One pulse per press: rising edge of the synchronized level
    assign step = sync_q[SYNC_STAGES-1] & ~delay_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], nextpulse};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A load strobe always wins over a simultaneous step
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        flg_d   = flg_q;
        if (resultvalid) begin
            state_d = SHOW;
            idx_d   = 3'd0;
            res_d   = result;
            flg_d   = flags;
        end else if (step) begin
            unique case (state_q)
                SHOW: begin
                    if (idx_q == LAST) begin
                        state_d = FIN;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        data_d = 8'h00;
        if (state_d == SHOW) begin
            if (idx_d == LAST) begin
                data_d = {4'b0000, flg_d};
            end else begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_d == 3'(i)) begin
                        data_d = res_d[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= 3'd0;
            res_q  <= '0;
            flg_q  <= 4'd0;
            data_q <= 8'h00;
        end else begin
            idx_q  <= idx_d;
            res_q  <= res_d;
            flg_q  <= flg_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        outputdata   = data_q;
        dataoutput_i = idx_q;
        busy         = (state_q == SHOW);
        done         = (state_q == FIN);
    end

endmodule

// File: tb/tb_peripheral_putresult.sv
// Randomized and directed checks of peripheral_putresult against an
// edge-history model of the button and a simple presentation model.
module tb_peripheral_putresult;

    logic        clk;
    logic        rst;
    logic [31:0] res_in;
    logic [3:0]  flg_in;
    logic        rv;
    logic        btn;
    logic [7:0]  outputdata;
    logic [2:0]  dataoutput_i;
    logic        busy;
    logic        done;

    int n_pass;
    int n_total;

    int          m_mode;
    int          m_idx;
    logic [31:0] m_res;
    logic [3:0]  m_flg;
    logic [2:0]  bh;

    peripheral_putresult #(
        .NBYTES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(rst),
        .result(res_in),
        .flags(flg_in),
        .resultvalid(rv),
        .nextpulse(btn),
        .outputdata(outputdata),
        .dataoutput_i(dataoutput_i),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] model_out();
        logic [7:0] d;
        logic [2:0] i;
        d = 8'h00;
        i = 3'd0;
        if (m_mode == 1) begin
            i = 3'(m_idx);
            if (m_idx == 4) d = {4'b0000, m_flg};
            else d = 8'(m_res >> (8 * m_idx));
        end
        return {m_mode == 1, m_mode == 2, i, d};
    endfunction

    function automatic logic [12:0] dut_out();
        return {busy, done, dataoutput_i, outputdata};
    endfunction

    task automatic model_clear();
        m_mode = 0;
        m_idx  = 0;
        m_res  = '0;
        m_flg  = '0;
        bh     = '0;
    endtask

    // Step at edge n exists when button was 1 at edge n-2 and 0 at edge n-3
    task automatic tick();
        logic        b;
        logic        v;
        logic [31:0] r;
        logic [3:0]  f;
        logic        st;
        b = btn;
        v = rv;
        r = res_in;
        f = flg_in;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            st = bh[1] & ~bh[2];
            bh = {bh[1:0], b};
            if (v) begin
                m_mode = 1;
                m_idx  = 0;
                m_res  = r;
                m_flg  = f;
            end else if (st) begin
                if (m_mode == 1) begin
                    if (m_idx == 4) begin
                        m_mode = 2;
                        m_idx  = 0;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end else if (m_mode == 2) begin
                    m_mode = 0;
                end
            end
        end
        #1;
    endtask

    task automatic load(input logic [31:0] r, input logic [3:0] f);
        res_in = r;
        flg_in = f;
        rv = 1'b1;
        tick();
        rv = 1'b0;
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (4) tick();
        btn = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn = 1'b0;
        rv = 1'b0;
        res_in = '0;
        flg_in = '0;
        model_clear();
        repeat (3) tick();
        n_total++;
        if (dut_out() !== 13'h0) $display("FAIL reset_outputs: got %h expected %h", dut_out(), 13'h0);
        else n_pass++;
        rst = 1'b1;
        repeat (3) tick();
        n_total++;
        if (dut_out() !== model_out()) $display("FAIL reset_release: got %h expected %h", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_sequence();
        logic [7:0] seq [5];
        seq[0] = 8'hEF;
        seq[1] = 8'hBE;
        seq[2] = 8'hAD;
        seq[3] = 8'hDE;
        seq[4] = 8'h05;
        load(32'hDEADBEEF, 4'b0101);
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (outputdata !== seq[k] || dataoutput_i !== 3'(k) || busy !== 1'b1)
                $display("FAIL seq_byte%0d: got %h/%0d expected %h/%0d", k, outputdata, dataoutput_i, seq[k], k);
            else n_pass++;
            n_total++;
            if (dut_out() !== model_out()) $display("FAIL seq_model%0d: got %h expected %h", k, dut_out(), model_out());
            else n_pass++;
            press();
        end
        n_total++;
        if (dut_out() !== 13'b0_1_000_00000000) $display("FAIL seq_done: got %h expected %h", dut_out(), 13'b0_1_000_00000000);
        else n_pass++;
        press();
        n_total++;
        if (dut_out() !== 13'h0 || model_out() !== 13'h0) $display("FAIL seq_idle: got %h expected %h", dut_out(), 13'h0);
        else n_pass++;
    endtask

    task automatic test_hold();
        load(32'h01020304, 4'hA);
        btn = 1'b1;
        repeat (2) tick();
        n_total++;
        if (dataoutput_i !== 3'd0) $display("FAIL hold_early: got %0d expected %0d", dataoutput_i, 0);
        else n_pass++;
        tick();
        n_total++;
        if (dataoutput_i !== 3'd1 || outputdata !== 8'h03) $display("FAIL hold_third_edge: got %0d/%h expected 1/03", dataoutput_i, outputdata);
        else n_pass++;
        repeat (47) tick();
        n_total++;
        if (dataoutput_i !== 3'd1 || dut_out() !== model_out()) $display("FAIL hold_single: got %h expected %h", dut_out(), model_out());
        else n_pass++;
        btn = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_collision();
        load(32'h55667788, 4'h3);
        press();
        press();
        n_total++;
        if (dataoutput_i !== 3'd2) $display("FAIL coll_setup: got %0d expected %0d", dataoutput_i, 2);
        else n_pass++;
        btn = 1'b1;
        repeat (2) tick();
        res_in = 32'hCAFEF00D;
        flg_in = 4'h9;
        rv = 1'b1;
        tick();
        rv = 1'b0;
        n_total++;
        if (dataoutput_i !== 3'd0 || outputdata !== 8'h0D || busy !== 1'b1)
            $display("FAIL coll_restart: got %0d/%h expected 0/0d", dataoutput_i, outputdata);
        else n_pass++;
        repeat (3) tick();
        btn = 1'b0;
        repeat (3) tick();
        n_total++;
        if (dut_out() !== model_out() || dataoutput_i !== 3'd0) $display("FAIL coll_noadv: got %h expected %h", dut_out(), model_out());
        else n_pass++;
    endtask

    task automatic test_inputs_ignored();
        int bad;
        logic [12:0] ref_out;
        bad = 0;
        load(32'h8899AABB, 4'h6);
        press();
        ref_out = model_out();
        for (int k = 0; k < 20; k++) begin
            res_in = $urandom;
            flg_in = 4'($urandom);
            tick();
            if (dut_out() !== ref_out) bad++;
        end
        n_total++;
        if (bad != 0 || outputdata !== 8'hAA) $display("FAIL inputs_ignored: got %h expected %h (%0d bad)", dut_out(), ref_out, bad);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_clear();
        tick();
        for (int k = 0; k < 12; k++) begin
            btn = k[0];
            tick();
            if (dut_out() !== 13'h0) bad++;
        end
        btn = 1'b1;
        repeat (10) begin
            tick();
            if (dut_out() !== 13'h0) bad++;
        end
        n_total++;
        if (bad != 0 || model_out() !== 13'h0) $display("FAIL bounce_idle: got %h expected %h (%0d bad)", dut_out(), 13'h0, bad);
        else n_pass++;
        btn = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        load(32'h0BADF00D, 4'hF);
        press();
        btn = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        n_total++;
        if (dut_out() !== 13'h0) $display("FAIL reset_async: got %h expected %h", dut_out(), 13'h0);
        else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        repeat (10) begin
            tick();
            if (dut_out() !== 13'h0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL reset_held_btn: got %h expected %h (%0d bad)", dut_out(), 13'h0, bad);
        else n_pass++;
        btn = 1'b0;
        repeat (4) tick();
        load(32'h11223344, 4'h0);
        n_total++;
        if (dataoutput_i !== 3'd0 || outputdata !== 8'h44 || busy !== 1'b1)
            $display("FAIL reset_reload: got %0d/%h/%b expected 0/44/1", dataoutput_i, outputdata, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        int hold;
        bad = 0;
        hold = 0;
        for (int k = 0; k < 600; k++) begin
            if (hold == 0) begin
                btn = ~btn;
                hold = $urandom_range(1, 6);
            end
            hold--;
            rv = ($urandom_range(0, 24) == 0);
            res_in = $urandom;
            flg_in = 4'($urandom);
            tick();
            if (dut_out() !== model_out()) begin
                bad++;
                if (bad < 5) $display("FAIL random_cycle%0d: got %h expected %h", k, dut_out(), model_out());
            end
        end
        rv = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL random_total: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_sequence();
        test_hold();
        test_collision();
        test_inputs_ignored();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
